// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, derives the ALU control code,
// forwards EX/MEM and MEM/WB results into the operands, and stalls decode on load-use.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wreg,
  input  logic [31:0] id_rd_data1,
  input  logic [31:0] id_rd_data2,
  input  logic [31:0] id_imm,
  input  logic        id_alusrc,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_regwrite,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_wreg,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_wreg,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic [3:0]  ALUcontrol,
  output logic [31:0] Operand1,
  output logic [31:0] Operand2,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_regwrite,
  output logic [4:0]  ex_wreg,
  output logic [31:0] ex_store_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam logic [3:0] CODE_ADD  = 4'b0010;
  localparam logic [3:0] CODE_SUB  = 4'b0110;
  localparam logic [3:0] CODE_AND  = 4'b0000;
  localparam logic [3:0] CODE_OR   = 4'b0001;
  localparam logic [3:0] CODE_NOR  = 4'b0011;
  localparam logic [3:0] CODE_SLL  = 4'b1001;
  localparam logic [3:0] CODE_ILL  = 4'b1111;

  typedef struct packed {
    logic          valid;
    logic [3:0]    code;
    logic [RW-1:0] shamt;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] wreg;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [DW-1:0] imm;
    logic          alusrc;
    logic          memread;
    logic          memwrite;
    logic          regwrite;
  } ex_regs_t;

  ex_regs_t      ex_q, ex_d, cap;
  logic [3:0]    code_dec;
  logic          legal;
  logic          hazard;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // ALU control decode from aluop/funct
  always_comb begin
    code_dec = CODE_ILL;
    legal    = 1'b1;
    unique case (id_aluop)
      2'b00: code_dec = CODE_ADD;
      2'b01: code_dec = CODE_SUB;
      2'b10: begin
        unique case (id_funct)
          6'b100000: code_dec = CODE_ADD;
          6'b100010: code_dec = CODE_SUB;
          6'b100100: code_dec = CODE_AND;
          6'b100101: code_dec = CODE_OR;
          6'b100111: code_dec = CODE_NOR;
          6'b000000: code_dec = CODE_SLL;
          default:   legal    = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Load-use: the load in EX writes a register decode is about to read
  assign hazard = ex_q.valid && ex_q.memread && (ex_q.wreg != '0) &&
                  ((ex_q.wreg == id_rs) ||
                   ((ex_q.wreg == id_rt) && (!id_alusrc || id_memwrite)));
  assign id_ready = !hazard;

  always_comb begin
    cap          = '0;
    cap.valid    = 1'b1;
    cap.code     = legal ? code_dec : CODE_ILL;
    cap.shamt    = id_shamt;
    cap.rs       = id_rs;
    cap.rt       = id_rt;
    cap.wreg     = id_wreg;
    cap.data1    = id_rd_data1;
    cap.data2    = id_rd_data2;
    cap.imm      = id_imm;
    cap.alusrc   = id_alusrc;
    cap.memread  = id_memread && legal;
    cap.memwrite = id_memwrite && legal;
    cap.regwrite = id_regwrite && legal;
    ex_d = '0;
    if (id_valid && !flush && !hazard) ex_d = cap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Forwarding: EX/MEM wins over MEM/WB, register 0 is never forwarded
  always_comb begin
    fwd_rs = ex_q.data1;
    if (ex_q.rs != '0 && exmem_regwrite && exmem_wreg == ex_q.rs)      fwd_rs = exmem_result;
    else if (ex_q.rs != '0 && memwb_regwrite && memwb_wreg == ex_q.rs) fwd_rs = memwb_result;
    fwd_rt = ex_q.data2;
    if (ex_q.rt != '0 && exmem_regwrite && exmem_wreg == ex_q.rt)      fwd_rt = exmem_result;
    else if (ex_q.rt != '0 && memwb_regwrite && memwb_wreg == ex_q.rt) fwd_rt = memwb_result;
  end

  always_comb begin
    if (ex_q.code == CODE_SLL) begin
      Operand1 = fwd_rt;
      Operand2 = DW'(ex_q.shamt);
    end else begin
      Operand1 = fwd_rs;
      Operand2 = ex_q.alusrc ? ex_q.imm : fwd_rt;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ALUcontrol    = ex_q.code;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_wreg       = ex_q.wreg;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: instruction-level reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt, id_rs, id_rt, id_wreg;
  logic [31:0] id_rd_data1, id_rd_data2, id_imm;
  logic        id_alusrc, id_memread, id_memwrite, id_regwrite;
  logic        flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_wreg, memwb_wreg;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic [3:0]  ALUcontrol;
  logic [31:0] Operand1, Operand2, ex_store_data;
  logic [4:0]  ex_wreg;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
    .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_regwrite(id_regwrite), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_wreg(memwb_wreg), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ALUcontrol(ALUcontrol), .Operand1(Operand1), .Operand2(Operand2),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_wreg(ex_wreg), .ex_store_data(ex_store_data)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the instruction currently sitting in EX
  logic        m_valid, m_alusrc, m_mr, m_mw, m_rw;
  logic [3:0]  m_code;
  logic [4:0]  m_shamt, m_rs, m_rt, m_wreg;
  logic [31:0] m_d1, m_d2, m_imm;

  function automatic logic [3:0] spec_code(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd15;
    case (f)
      6'h20:   return 4'd2;
      6'h22:   return 4'd6;
      6'h24:   return 4'd0;
      6'h25:   return 4'd1;
      6'h27:   return 4'd3;
      6'h00:   return 4'd9;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_mr && m_wreg != 5'd0 &&
           (m_wreg == id_rs || (m_wreg == id_rt && (!id_alusrc || id_memwrite)));
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return rf;
    if (exmem_regwrite && exmem_wreg == src) return exmem_result;
    if (memwb_regwrite && memwb_wreg == src) return memwb_result;
    return rf;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || flush || m_hazard() || !id_valid) begin
      m_valid <= 1'b0; m_code <= 4'd0; m_shamt <= 5'd0; m_rs <= 5'd0; m_rt <= 5'd0;
      m_wreg <= 5'd0; m_d1 <= 32'd0; m_d2 <= 32'd0; m_imm <= 32'd0;
      m_alusrc <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_rw <= 1'b0;
    end else begin
      m_valid <= 1'b1; m_code <= spec_code(id_aluop, id_funct);
      m_shamt <= id_shamt; m_rs <= id_rs; m_rt <= id_rt; m_wreg <= id_wreg;
      m_d1 <= id_rd_data1; m_d2 <= id_rd_data2; m_imm <= id_imm; m_alusrc <= id_alusrc;
      m_mr <= id_memread  && spec_code(id_aluop, id_funct) != 4'd15;
      m_mw <= id_memwrite && spec_code(id_aluop, id_funct) != 4'd15;
      m_rw <= id_regwrite && spec_code(id_aluop, id_funct) != 4'd15;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] e1, e2;
      if (m_code == 4'd9) begin
        e1 = fwd(m_rt, m_d2); e2 = {27'd0, m_shamt};
      end else begin
        e1 = fwd(m_rs, m_d1); e2 = m_alusrc ? m_imm : fwd(m_rt, m_d2);
      end
      check("m_ex_valid", 32'(ex_valid), 32'(m_valid));
      check("m_ALUcontrol", 32'(ALUcontrol), 32'(m_code));
      check("m_Operand1", Operand1, e1);
      check("m_Operand2", Operand2, e2);
      check("m_store", ex_store_data, fwd(m_rt, m_d2));
      check("m_ctrl", {29'd0, ex_memread, ex_memwrite, ex_regwrite}, {29'd0, m_mr, m_mw, m_rw});
      check("m_wreg", 32'(ex_wreg), 32'(m_wreg));
      check("m_id_ready", 32'(id_ready), 32'(!m_hazard()));
    end
  end

  task automatic idle();
    id_valid = 0; id_aluop = 0; id_funct = 0; id_shamt = 0; id_rs = 0; id_rt = 0;
    id_wreg = 0; id_rd_data1 = 0; id_rd_data2 = 0; id_imm = 0; id_alusrc = 0;
    id_memread = 0; id_memwrite = 0; id_regwrite = 0; flush = 0;
    exmem_regwrite = 0; exmem_wreg = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_wreg = 0; memwb_result = 0;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    idle();
    id_valid = 1; id_aluop = 2'b10; id_funct = f; id_rs = rs; id_rt = rt; id_wreg = rd;
    id_rd_data1 = d1; id_rd_data2 = d2; id_regwrite = 1;
  endtask

  task automatic load(input logic [4:0] rs, input logic [4:0] rt);
    idle();
    id_valid = 1; id_aluop = 2'b00; id_rs = rs; id_wreg = rt; id_alusrc = 1;
    id_memread = 1; id_regwrite = 1; id_imm = 32'd4; id_rd_data1 = 32'h100;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    // Reset with random inputs on the decode side
    id_valid = 1; id_aluop = 2'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
    id_rd_data1 = $urandom; id_rd_data2 = $urandom; id_regwrite = 1;
    exmem_regwrite = 1; exmem_wreg = 5'($urandom); exmem_result = $urandom;
    @(posedge clk);
    cmp_en = 1;
    tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_code", 32'(ALUcontrol), 32'd0);
    check("rst_op1", Operand1, 32'd0);
    check("rst_op2", Operand2, 32'd0);
    check("rst_ctrl", {27'd0, ex_wreg}, 32'd0);

    rst_n = 1;
    rtype(6'b100010, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3);
    tick();
    check("sub_code", 32'(ALUcontrol), 32'd6);
    check("sub_op1", Operand1, 32'd7);
    check("sub_op2", Operand2, 32'd3);
    check("sub_rw", 32'(ex_regwrite), 32'd1);

    rtype(6'b000000, 5'd0, 5'd2, 5'd3, 32'd0, 32'h1);
    id_shamt = 5'd4;
    tick();
    check("sll_op1", Operand1, 32'h1);
    check("sll_op2", Operand2, 32'd4);
    check("sll_code", 32'(ALUcontrol), 32'd9);

    idle();
    id_valid = 1; id_aluop = 2'b00; id_alusrc = 1; id_imm = 32'hFFFF_FFFC; id_regwrite = 1;
    tick();
    check("imm_op2", Operand2, 32'hFFFF_FFFC);
    check("imm_code", 32'(ALUcontrol), 32'd2);

    rtype(6'b100000, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22);
    exmem_regwrite = 1; exmem_wreg = 5'd5; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_wreg = 5'd5; memwb_result = 32'hBB;
    tick();
    check("fwd_exmem", Operand1, 32'hAA);
    exmem_regwrite = 0;
    #1;
    check("fwd_memwb_same_cycle", Operand1, 32'hBB);

    rtype(6'b100000, 5'd0, 5'd0, 5'd7, 32'h55, 32'h66);
    exmem_regwrite = 1; exmem_wreg = 5'd0; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_wreg = 5'd0; memwb_result = 32'hBB;
    tick();
    check("r0_op1", Operand1, 32'h55);
    check("r0_op2", Operand2, 32'h66);

    // Load-use: lw r8 then add r9,r8,r1
    load(5'd1, 5'd8);
    tick();
    rtype(6'b100000, 5'd8, 5'd1, 5'd9, 32'h0, 32'h5);
    #1;
    check("lu_stall", 32'(id_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_ready", 32'(id_ready), 32'd1);
    memwb_regwrite = 1; memwb_wreg = 5'd8; memwb_result = 32'h1234;
    tick();
    check("lu_valid", 32'(ex_valid), 32'd1);
    check("lu_op1", Operand1, 32'h1234);
    check("lu_op2", Operand2, 32'h5);

    rtype(6'b100000, 5'd1, 5'd2, 5'd3, 32'h9, 32'h9);
    flush = 1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_code", 32'(ALUcontrol), 32'd0);

    // Flush during a load-use stall
    load(5'd1, 5'd8);
    tick();
    rtype(6'b100000, 5'd8, 5'd1, 5'd9, 32'h0, 32'h5);
    flush = 1;
    #1;
    check("fh_ready", 32'(id_ready), 32'd0);
    tick();
    check("fh_valid", 32'(ex_valid), 32'd0);

    // Reset during a load-use stall
    load(5'd1, 5'd8);
    tick();
    rtype(6'b100000, 5'd2, 5'd8, 5'd9, 32'h0, 32'h5);
    #1;
    check("rs_stall", 32'(id_ready), 32'd0);
    rst_n = 0;
    tick();
    check("rs_valid", 32'(ex_valid), 32'd0);
    check("rs_ready", 32'(id_ready), 32'd1);
    rst_n = 1;

    rtype(6'b101010, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    tick();
    check("ill_code", 32'(ALUcontrol), 32'hF);
    check("ill_rw", 32'(ex_regwrite), 32'd0);
    check("ill_valid", 32'(ex_valid), 32'd1);

    idle();
    id_aluop = 2'b11; id_valid = 1; id_memwrite = 1; id_memread = 1;
    tick();
    check("op11_code", 32'(ALUcontrol), 32'hF);
    check("op11_ctrl", {30'd0, ex_memread, ex_memwrite}, 32'd0);

    rtype(6'b100000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
    id_valid = 0;
    tick();
    check("inv_valid", 32'(ex_valid), 32'd0);
    check("inv_code", 32'(ALUcontrol), 32'd0);

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 40; i++) begin
      logic [5:0] fl [7];
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h2a};
      idle();
      id_valid = ($urandom_range(0, 5) != 0);
      id_aluop = 2'($urandom); id_funct = fl[$urandom_range(0, 6)];
      id_shamt = 5'($urandom); id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7)); id_wreg = 5'($urandom_range(0, 7));
      id_rd_data1 = $urandom; id_rd_data2 = $urandom; id_imm = $urandom;
      id_alusrc = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
      id_regwrite = 1'($urandom); flush = ($urandom_range(0, 7) == 0);
      exmem_regwrite = 1'($urandom); exmem_wreg = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_wreg = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      tick();
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
